// File: rtl/store_merge_pkg.sv
// Shared encodings for the sub-word store path: size codes, FSM states and
// byte-lane helpers used by store_merge_unit and store_lane_merge.
package store_merge_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_ERR
    } state_e;

    localparam int LANE_W = 8;
    localparam int HALF_W = 16;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Natural alignment: halves on even bytes, words on word boundaries.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_HALF:    is_illegal = addr_lo[0];
            SZ_WORD:    is_illegal = (addr_lo != 2'b00);
            SZ_ILLEGAL: is_illegal = 1'b1;
            default:    is_illegal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational byte/half lane merge of store data into an old memory word.
// Define STORE_MERGE_BIG_ENDIAN_EN for big-endian lane mapping (default little-endian).
module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    output logic [31:0] o_merged
);

    logic [1:0] w_lane;
    logic       w_half_hi;

`ifdef STORE_MERGE_BIG_ENDIAN_EN
    // Byte address 0 lands in the most significant lane.
    assign w_lane    = ~i_addr_lo;
    assign w_half_hi = ~i_addr_lo[1];
`else
    assign w_lane    = i_addr_lo;
    assign w_half_hi = i_addr_lo[1];
`endif

    always_comb begin
        o_merged = i_old;
        case (i_size)
            SZ_BYTE: begin
                case (w_lane)
                    LANE_0:  o_merged[0*LANE_W +: LANE_W] = i_data[LANE_W-1:0];
                    LANE_1:  o_merged[1*LANE_W +: LANE_W] = i_data[LANE_W-1:0];
                    LANE_2:  o_merged[2*LANE_W +: LANE_W] = i_data[LANE_W-1:0];
                    default: o_merged[3*LANE_W +: LANE_W] = i_data[LANE_W-1:0];
                endcase
            end
            SZ_HALF: begin
                if (w_half_hi)
                    o_merged[HALF_W +: HALF_W] = i_data[HALF_W-1:0];
                else
                    o_merged[0 +: HALF_W] = i_data[HALF_W-1:0];
            end
            SZ_WORD: o_merged = i_data;
            default: o_merged = i_old;
        endcase
    end

endmodule

// File: rtl/store_merge_unit.sv
// Sub-word store sequencer: SB/SH via read-modify-write, SW straight through.
// Lane mapping follows STORE_MERGE_BIG_ENDIAN_EN inside store_lane_merge.
module store_merge_unit
    import store_merge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_rd_valid,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wr_data,
    output logic              done,
    output logic              misaligned
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [1:0]        r_size;
    logic [31:0]       r_wr_data;
    logic [31:0]       w_merged;
    logic              w_accept;
    logic              w_illegal;

    assign w_accept  = (r_state == ST_IDLE) && req_valid;
    assign w_illegal = is_illegal(req_size, req_addr[1:0]);

    store_lane_merge u_merge (
        .i_old     (mem_rd_data),
        .i_data    (r_data),
        .i_addr_lo (r_addr[1:0]),
        .i_size    (r_size),
        .o_merged  (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_illegal)              w_next = ST_ERR;
                    else if (req_size == SZ_WORD) w_next = ST_WRITE;
                    else                        w_next = ST_READ;
                end
            end
            ST_READ:  w_next = ST_WAIT;
            ST_WAIT:  if (mem_rd_valid) w_next = ST_WRITE;
            ST_WRITE: w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Request capture on accept; write data either bypassed (SW) or merged on read return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_size    <= SZ_BYTE;
            r_wr_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_data <= req_data;
                r_size <= req_size;
                if (!w_illegal && (req_size == SZ_WORD))
                    r_wr_data <= req_data;
            end
            if ((r_state == ST_WAIT) && mem_rd_valid)
                r_wr_data <= w_merged;
        end
    end

    assign req_ready   = (r_state == ST_IDLE);
    assign mem_rd_en   = (r_state == ST_READ);
    assign mem_wr_en   = (r_state == ST_WRITE);
    assign done        = (r_state == ST_WRITE);
    assign misaligned  = (r_state == ST_ERR);
    assign mem_addr    = r_addr[ADDR_W-1:2];
    assign mem_wr_data = r_wr_data;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit; expected words follow STORE_MERGE_BIG_ENDIAN_EN.
module tb_store_merge_unit;

    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic [ADDR_W-3:0] mem_addr;
    logic              mem_rd_en;
    logic [31:0]       mem_rd_data;
    logic              mem_rd_valid;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;
    logic              done;
    logic              misaligned;

    int n_assert = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_wr     = 0;
    int rd0;
    int wr0;

`ifdef STORE_MERGE_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_SB101 = 32'h11AB3344;
    localparam logic [31:0] EXP_SH102 = 32'h1122BEEF;
    localparam logic [31:0] EXP_SB000 = 32'hAB223344;
`else
    localparam logic [31:0] EXP_SB101 = 32'h1122AB44;
    localparam logic [31:0] EXP_SH102 = 32'hBEEF3344;
    localparam logic [31:0] EXP_SB000 = 32'h112233AB;
`endif

    store_merge_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_data  (mem_wr_data),
        .done         (done),
        .misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_rd_en) n_rd++;
        if (mem_wr_en) n_wr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_size  = size;
        step();
        req_valid = 1'b0;
    endtask

    task automatic check_idle_out(input string tag);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        check({tag, "_rd"}, {31'b0, mem_rd_en}, 32'd0);
        check({tag, "_wr"}, {31'b0, mem_wr_en}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_mis"}, {31'b0, misaligned}, 32'd0);
    endtask

    task automatic bad_req(input string tag, input logic [31:0] addr, input logic [1:0] size);
        rd0 = n_rd;
        wr0 = n_wr;
        issue(addr, 32'hCAFEF00D, size);
        check({tag, "_mis_t1"}, {31'b0, misaligned}, 32'd1);
        check({tag, "_rd_t1"}, {31'b0, mem_rd_en}, 32'd0);
        check({tag, "_wr_t1"}, {31'b0, mem_wr_en}, 32'd0);
        step();
        check_idle_out({tag, "_t2"});
        check({tag, "_strobes"}, n_rd - rd0 + n_wr - wr0, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_data     = '0;
        req_size     = 2'b00;
        mem_rd_data  = 32'h11223344;
        mem_rd_valid = 1'b0;
        step();
        step();
        check_idle_out("rst");
        check("rst_addr", {2'b0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wr_data, 32'd0);
        rst_n = 1'b1;
        step();

        // SB 0x101 with the read returning as early as allowed.
        rd0 = n_rd;
        issue(32'h101, 32'hFFFFFFAB, 2'b00);
        check("sb_rd_t1", {31'b0, mem_rd_en}, 32'd1);
        check("sb_ready_t1", {31'b0, req_ready}, 32'd0);
        check("sb_addr", {2'b0, mem_addr}, 32'h40);
        mem_rd_valid = 1'b1;
        step();
        check("sb_rd_t2", {31'b0, mem_rd_en}, 32'd0);
        check("sb_wr_t2", {31'b0, mem_wr_en}, 32'd0);
        step();
        mem_rd_valid = 1'b0;
        check("sb_wr_t3", {31'b0, mem_wr_en}, 32'd1);
        check("sb_done_t3", {31'b0, done}, 32'd1);
        check("sb_wdata", mem_wr_data, EXP_SB101);
        step();
        check_idle_out("sb_t4");
        check("sb_nrd", n_rd - rd0, 32'd1);

        // SH 0x102 with read data delayed four cycles.
        rd0 = n_rd;
        issue(32'h102, 32'h0000BEEF, 2'b01);
        check("sh_rd_t1", {31'b0, mem_rd_en}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("sh_wait_rd", {31'b0, mem_rd_en}, 32'd0);
            check("sh_wait_wr", {31'b0, mem_wr_en}, 32'd0);
        end
        mem_rd_valid = 1'b1;
        step();
        mem_rd_valid = 1'b0;
        check("sh_wr", {31'b0, mem_wr_en}, 32'd1);
        check("sh_done", {31'b0, done}, 32'd1);
        check("sh_wdata", mem_wr_data, EXP_SH102);
        check("sh_nrd", n_rd - rd0, 32'd1);
        step();
        check_idle_out("sh_end");

        // SW 0x8 straight through, then a second SW back-to-back.
        rd0 = n_rd;
        issue(32'h8, 32'hDEADBEEF, 2'b10);
        check("sw_wr_t1", {31'b0, mem_wr_en}, 32'd1);
        check("sw_done_t1", {31'b0, done}, 32'd1);
        check("sw_wdata", mem_wr_data, 32'hDEADBEEF);
        check("sw_ready_t1", {31'b0, req_ready}, 32'd0);
        check("sw_addr", {2'b0, mem_addr}, 32'h2);
        step();
        check_idle_out("sw_t2");
        issue(32'h10, 32'h01234567, 2'b10);
        check("sw2_wr_t1", {31'b0, mem_wr_en}, 32'd1);
        check("sw2_wdata", mem_wr_data, 32'h01234567);
        check("sw2_addr", {2'b0, mem_addr}, 32'h4);
        check("sw_nrd", n_rd - rd0, 32'd0);
        step();

        // Illegal requests.
        bad_req("sh3", 32'h3, 2'b01);
        bad_req("sw6", 32'h6, 2'b10);
        bad_req("sz11", 32'h0, 2'b11);

        // Reset while waiting for read data.
        wr0 = n_wr;
        issue(32'h101, 32'h000000EE, 2'b00);
        step();
        check("rw_wait_ready", {31'b0, req_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_idle_out("rw_rst");
        check("rw_rst_addr", {2'b0, mem_addr}, 32'd0);
        check("rw_rst_wdata", mem_wr_data, 32'd0);
        mem_rd_valid = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
        mem_rd_valid = 1'b0;
        step();
        check_idle_out("rw_after");
        check("rw_nwr", n_wr - wr0, 32'd0);

        // Normal SB after the abort.
        issue(32'h0, 32'h000000AB, 2'b00);
        check("sb0_rd", {31'b0, mem_rd_en}, 32'd1);
        check("sb0_addr", {2'b0, mem_addr}, 32'd0);
        mem_rd_valid = 1'b1;
        step();
        step();
        mem_rd_valid = 1'b0;
        check("sb0_wr", {31'b0, mem_wr_en}, 32'd1);
        check("sb0_wdata", mem_wr_data, EXP_SB000);
        step();
        check_idle_out("sb0_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Sub-word store path for the MIPS datapath: the counterpart of load-side sign extension. The unit takes a 32-bit register value and a store size (SB/SH/SW) and narrows it into the correct byte lanes of a 32-bit word memory. Byte and halfword stores use a read-modify-write sequence; word stores go straight through. It sits between the execute stage's store request and the word-addressed data memory.

## Interface
- ADDR_W, 32, byte-address width; the memory word address is ADDR_W-2 bits.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle and accepting; a request is accepted when req_valid && req_ready.
- req_addr  input  ADDR_W  byte address.
- req_data  input  32  register value; the low byte or low halfword is used for SB/SH.
- req_size  input  2  00=byte, 01=half, 10=word, 11=illegal.
- mem_addr  output  ADDR_W-2  word address (latched req_addr[ADDR_W-1:2]).
- mem_rd_en  output  1  one-cycle read strobe.
- mem_rd_data  input  32  read word.
- mem_rd_valid  input  1  mem_rd_data valid; sampled only in WAIT.
- mem_wr_en  output  1  one-cycle write strobe.
- mem_wr_data  output  32  merged word.
- done  output  1  one-cycle pulse, coincident with mem_wr_en.
- misaligned  output  1  one-cycle pulse for a rejected request.

## Operation
- States: IDLE, READ, WAIT, WRITE, ERR. Reset enters IDLE.
- IDLE: req_ready=1. On accept, latch addr, data and size.
  - Illegal (size=11, half with addr[0]=1, word with addr[1:0]!=0) -> ERR.
  - Word -> WRITE with mem_wr_data=req_data.
  - Otherwise -> READ.
- READ: mem_rd_en=1 for exactly one cycle, -> WAIT.
- WAIT: hold until mem_rd_valid=1. On that edge, register the merged word -> WRITE. The wait is unbounded.
- WRITE: mem_wr_en=1, done=1 -> IDLE.
- ERR: misaligned=1. No mem_rd_en or mem_wr_en is issued -> IDLE.
- Merge, little-endian:
  - Byte: lane addr[1:0] (lane 0 = bits 7:0) gets req_data[7:0].
  - Half: addr[1]=0 replaces bits 15:0, addr[1]=1 replaces bits 31:16, with req_data[15:0].
  - All other bits come from mem_rd_data.
- mem_addr holds its latched value from accept until the next accept.
- Reset values: req_ready=1 (IDLE), mem_rd_en=0, mem_wr_en=0, done=0, misaligned=0, mem_addr=0, mem_wr_data=0.
- Reset mid-operation (READ/WAIT/WRITE) aborts immediately. No write is issued afterward, and a pending mem_rd_valid is ignored.

## Timing
- Accept at edge T.
- Word store: WRITE during cycle T+1 (mem_wr_en, done high). req_ready returns at T+2. Throughput is one word store per 2 cycles.
- Sub-word store: READ during T+1. mem_rd_valid can be sampled at the earliest in T+2. If it is sampled at edge R, WRITE is during R+1 and IDLE at R+2. Minimum latency is 3 cycles accept-to-done.
- Illegal request: misaligned high during T+1, IDLE at T+2.
- All strobes are Moore outputs decoded from registered state. There is no combinational path from req_* or mem_rd_* to any output.
- A request presented while req_ready=0 is ignored and not queued.

## Configuration
- STORE_MERGE_BIG_ENDIAN_EN defined:
  - Lane mapping is big-endian: addr[1:0]=0 is bits 31:24.
  - Half addr[1]=0 replaces bits 31:16.
- Undefined: little-endian mapping as above.
- Alignment rules and timing are identical in both modes.

## Structure
- Package store_merge_pkg:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILLEGAL.
  - FSM state typedef.
  - Lane-select helper constants.
- Sub-module store_lane_merge: purely combinational (old word, data, addr[1:0], size) -> merged word. It owns the endianness macro.
- The FSM and registers stay in store_merge_unit.

## Test plan
- Memory word 0x11223344, SB addr 0x101 data 0xFFFFFFAB -> one read; write 0x1122AB44; done together with mem_wr_en; mem_addr=0x40.
- SH addr 0x102 data 0x0000BEEF over 0x11223344 -> write 0xBEEF3344. With mem_rd_valid delayed 4 cycles, mem_rd_en stays single-cycle and the write follows 1 cycle after valid.
- SW addr 0x8 data 0xDEADBEEF -> no mem_rd_en; mem_wr_en at T+1 with 0xDEADBEEF; req_ready high at T+2.
- SH addr 0x3, SW addr 0x6, size=11 -> misaligned pulse at T+1 each; zero mem_rd_en/mem_wr_en.
- Reset asserted in WAIT, then mem_rd_valid pulsed -> no mem_wr_en; all outputs at reset values; next SB completes normally.
- STORE_MERGE_BIG_ENDIAN_EN: SB addr 0x0 data 0xAB over 0x11223344 -> 0xAB223344.
